// File: rtl/ram_access_arbiter_pkg.sv
// Shared widths, types and the round-robin pick helper for the RAM access arbiter.
package ram_arb_pkg;

    localparam int RAM_NREQ   = 2;
    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DATA_W = 8;

    typedef logic [RAM_ADDR_W-1:0] addr_t;
    typedef logic [RAM_DATA_W-1:0] data_t;
    typedef logic [RAM_NREQ-1:0]   req_vec_t;

    // Works on up to 8 requesters; only the low n bits of req are considered.
    function automatic logic [7:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int unsigned n);
        logic [7:0]  gnt;
        logic        found;
        int unsigned idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < n && !found) begin
                idx = (32'(ptr) + i) % n;
                if (req[idx[2:0]]) begin
                    gnt[idx[2:0]] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Client-side and RAM-side signal bundle of the RAM access arbiter.
interface ram_access_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) ();
    logic [NREQ-1:0]        wr_req;
    logic [NREQ*ADDR_W-1:0] wr_addr;
    logic [NREQ*DATA_W-1:0] wr_data;
    logic [NREQ-1:0]        wr_gnt;
    logic [NREQ-1:0]        rd_req;
    logic [NREQ*ADDR_W-1:0] rd_addr;
    logic [NREQ-1:0]        rd_gnt;
    logic [NREQ-1:0]        rd_rsp_valid;
    logic [DATA_W-1:0]      rd_rsp_data;
    logic                   ram_ena;
    logic                   ram_wea;
    logic [ADDR_W-1:0]      ram_addra;
    logic [DATA_W-1:0]      ram_dina;
    logic                   ram_enb;
    logic [ADDR_W-1:0]      ram_addrb;
    logic [DATA_W-1:0]      ram_doutb;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_doutb,
        output wr_gnt, rd_gnt, rd_rsp_valid, rd_rsp_data,
               ram_ena, ram_wea, ram_addra, ram_dina, ram_enb, ram_addrb
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_doutb,
        input  wr_gnt, rd_gnt, rd_rsp_valid, rd_rsp_data,
               ram_ena, ram_wea, ram_addra, ram_dina, ram_enb, ram_addrb
    );
endinterface

// File: rtl/ram_access_arbiter_rr_arbiter.sv
// Round-robin arbiter: cand_o is the unqualified winner, gnt_o is that winner gated by en_i.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] cand_o,
    output logic [NREQ-1:0] gnt_o
);
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] req_ext;
    logic [7:0] pick;

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req_i;
    end

    assign pick   = rr_pick(req_ext, ptr_q, NREQ);
    assign cand_o = pick[NREQ-1:0];
    assign gnt_o  = en_i ? cand_o : '0;

    // Pointer moves past the winner only when the grant is actually issued.
    always_comb begin
        ptr_d = ptr_q;
        for (int k = 0; k < 8; k++) begin
            if (en_i && pick[k]) ptr_d = 3'((k + 1) % NREQ);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/ram_access_arbiter.sv
// Shares a simple dual-port RAM between NREQ clients: writes on port A, reads on port B.
// Optional RAM_ARB_RAW_BYPASS_EN: forward same-cycle write data to a colliding read instead of stalling it.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ   = RAM_NREQ,
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ram_access_arbiter_if.slave  bus
);
    logic [NREQ-1:0]   wr_cand, wr_gnt;
    logic [NREQ-1:0]   rd_cand, rd_gnt;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [DATA_W-1:0] wdata;
    logic              hazard;
    logic              rd_en;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;

    rr_arbiter #(.NREQ(NREQ)) u_wr_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (bus.wr_req),
        .en_i   (rst_n),
        .cand_o (wr_cand),
        .gnt_o  (wr_gnt)
    );

    rr_arbiter #(.NREQ(NREQ)) u_rd_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (bus.rd_req),
        .en_i   (rd_en),
        .cand_o (rd_cand),
        .gnt_o  (rd_gnt)
    );

    always_comb begin
        waddr = '0;
        wdata = '0;
        raddr = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (wr_gnt[k]) begin
                waddr = bus.wr_addr[k*ADDR_W +: ADDR_W];
                wdata = bus.wr_data[k*DATA_W +: DATA_W];
            end
            if (rd_cand[k]) raddr = bus.rd_addr[k*ADDR_W +: ADDR_W];
        end
    end

    // wr_gnt is already zero in reset, so wr_cand only matters through it.
    assign hazard = (|wr_gnt) && (|wr_cand) && (|rd_cand) && (waddr == raddr);

    assign bus.wr_gnt    = wr_gnt;
    assign bus.ram_ena   = |wr_gnt;
    assign bus.ram_wea   = |wr_gnt;
    assign bus.ram_addra = waddr;
    assign bus.ram_dina  = wdata;

    assign bus.rd_gnt    = rd_gnt;
    assign bus.ram_enb   = |rd_gnt;
    assign bus.ram_addrb = (|rd_gnt) ? raddr : '0;

    assign rsp_valid_d      = rd_gnt;
    assign bus.rd_rsp_valid = rsp_valid_q;

`ifdef RAM_ARB_RAW_BYPASS_EN
    logic              byp_valid_q;
    logic [DATA_W-1:0] byp_data_q;

    assign rd_en           = rst_n;
    assign bus.rd_rsp_data = byp_valid_q ? byp_data_q : bus.ram_doutb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byp_valid_q <= 1'b0;
            byp_data_q  <= '0;
        end else begin
            byp_valid_q <= hazard;
            byp_data_q  <= hazard ? wdata : '0;
        end
    end
`else
    // Stall the colliding read one cycle so the RAM returns the new data.
    assign rd_en           = rst_n && !hazard;
    assign bus.rd_rsp_data = bus.ram_doutb;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) rsp_valid_q <= '0;
        else        rsp_valid_q <= rsp_valid_d;
    end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a read-first dual-port RAM model.
`timescale 1ns/1ps
module tb_ram_access_arbiter;
    localparam int NREQ   = 2;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    ram_access_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_access_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first RAM: a same-cycle read of a written address returns the old word.
    always @(posedge clk) begin
        if (bus.ram_ena && bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
        if (bus.ram_enb) bus.ram_doutb <= mem[bus.ram_addrb];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[10'h005] = 8'h5A;
        mem[10'h010] = 8'h77;
        bus.ram_doutb = '0;
        rst_n        = 1'b0;
        bus.wr_req   = 2'b11;
        bus.rd_req   = 2'b11;
        bus.wr_addr  = {10'h101, 10'h100};
        bus.wr_data  = {8'hA1, 8'hA0};
        bus.rd_addr  = {10'h005, 10'h000};

        // Reset with all requests high
        tick();
        tick();
        chk("rst_wr_gnt", 32'(bus.wr_gnt), 32'h0);
        chk("rst_rd_gnt", 32'(bus.rd_gnt), 32'h0);
        chk("rst_ena", 32'(bus.ram_ena), 32'h0);
        chk("rst_wea", 32'(bus.ram_wea), 32'h0);
        chk("rst_enb", 32'(bus.ram_enb), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rd_rsp_valid), 32'h0);

        // Release: client 0 first on both ports, then write round robin
        rst_n = 1'b1;
        #1;
        chk("rel_wr_gnt", 32'(bus.wr_gnt), 32'h1);
        chk("rel_rd_gnt", 32'(bus.rd_gnt), 32'h1);
        chk("rr0_addra", 32'(bus.ram_addra), 32'h100);
        chk("rr0_dina", 32'(bus.ram_dina), 32'hA0);
        tick();
        bus.rd_req = 2'b00;
        #1;
        chk("rel_rsp_valid", 32'(bus.rd_rsp_valid), 32'h1);
        chk("rel_rsp_data", 32'(bus.rd_rsp_data), 32'h00);
        chk("rr1_wr_gnt", 32'(bus.wr_gnt), 32'h2);
        chk("rr1_addra", 32'(bus.ram_addra), 32'h101);
        chk("rr1_dina", 32'(bus.ram_dina), 32'hA1);
        tick();
        chk("rr2_wr_gnt", 32'(bus.wr_gnt), 32'h1);
        chk("rr2_addra", 32'(bus.ram_addra), 32'h100);
        chk("rr_rd_idle_enb", 32'(bus.ram_enb), 32'h0);
        tick();
        chk("rr3_wr_gnt", 32'(bus.wr_gnt), 32'h2);
        chk("rr3_addra", 32'(bus.ram_addra), 32'h101);
        tick();
        bus.wr_req = 2'b00;
        #1;
        chk("idle_ena", 32'(bus.ram_ena), 32'h0);
        chk("idle_addra", 32'(bus.ram_addra), 32'h0);

        // Read latency: client 1 reads 0x005
        bus.rd_req = 2'b10;
        #1;
        chk("lat_rd_gnt", 32'(bus.rd_gnt), 32'h2);
        chk("lat_enb", 32'(bus.ram_enb), 32'h1);
        chk("lat_addrb", 32'(bus.ram_addrb), 32'h005);
        tick();
        bus.rd_req = 2'b00;
        #1;
        chk("lat_rsp_valid", 32'(bus.rd_rsp_valid), 32'h2);
        chk("lat_rsp_data", 32'(bus.rd_rsp_data), 32'h5A);
        tick();
        chk("lat_rsp_done", 32'(bus.rd_rsp_valid), 32'h0);

        // Write/read collision on 0x010
        bus.wr_addr = {10'h000, 10'h010};
        bus.wr_data = {8'h00, 8'h33};
        bus.rd_addr = {10'h010, 10'h005};
        bus.wr_req  = 2'b01;
        bus.rd_req  = 2'b10;
        #1;
        chk("haz_wr_gnt", 32'(bus.wr_gnt), 32'h1);
`ifdef RAM_ARB_RAW_BYPASS_EN
        chk("haz_rd_gnt", 32'(bus.rd_gnt), 32'h2);
        tick();
        bus.wr_req = 2'b00;
        bus.rd_req = 2'b00;
        #1;
        chk("haz_rsp_valid", 32'(bus.rd_rsp_valid), 32'h2);
        chk("haz_rsp_data", 32'(bus.rd_rsp_data), 32'h33);
`else
        chk("haz_rd_gnt", 32'(bus.rd_gnt), 32'h0);
        chk("haz_enb", 32'(bus.ram_enb), 32'h0);
        tick();
        bus.wr_req = 2'b00;
        #1;
        chk("haz_retry_gnt", 32'(bus.rd_gnt), 32'h2);
        chk("haz_stall_valid", 32'(bus.rd_rsp_valid), 32'h0);
        tick();
        bus.rd_req = 2'b00;
        #1;
        chk("haz_rsp_valid", 32'(bus.rd_rsp_valid), 32'h2);
        chk("haz_rsp_data", 32'(bus.rd_rsp_data), 32'h33);
`endif
        tick();

        // Reset mid-read: move both pointers to 1, then reset with a read in flight
        bus.wr_addr = {10'h201, 10'h200};
        bus.wr_data = {8'h22, 8'h11};
        bus.rd_addr = {10'h010, 10'h005};
        bus.wr_req  = 2'b01;
        bus.rd_req  = 2'b01;
        #1;
        chk("mid_a_wr_gnt", 32'(bus.wr_gnt), 32'h1);
        chk("mid_a_rd_gnt", 32'(bus.rd_gnt), 32'h1);
        tick();
        bus.wr_req = 2'b11;
        bus.rd_req = 2'b11;
        #1;
        chk("mid_t_wr_gnt", 32'(bus.wr_gnt), 32'h2);
        chk("mid_t_rd_gnt", 32'(bus.rd_gnt), 32'h2);
        chk("mid_t_rsp_valid", 32'(bus.rd_rsp_valid), 32'h1);
        chk("mid_t_rsp_data", 32'(bus.rd_rsp_data), 32'h5A);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_gnt", 32'(bus.rd_gnt), 32'h0);
        chk("mid_rst_enb", 32'(bus.ram_enb), 32'h0);
        chk("mid_rst_ena", 32'(bus.ram_ena), 32'h0);
        tick();
        chk("mid_t1_rsp_valid", 32'(bus.rd_rsp_valid), 32'h0);
        tick();
        chk("mid_t2_rsp_valid", 32'(bus.rd_rsp_valid), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("mid_ptr_wr_gnt", 32'(bus.wr_gnt), 32'h1);
        chk("mid_ptr_rd_gnt", 32'(bus.rd_gnt), 32'h1);
        tick();
        bus.wr_req = 2'b00;
        bus.rd_req = 2'b00;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Round-robin arbiter that shares one simple dual-port block RAM between NREQ clients.
- Write requests are steered to RAM port A and read requests to RAM port B, each with an independent arbiter.
- Returns read data with a one-hot response tag and resolves same-cycle write/read address hazards.
- Sits between client engines and the RAM instance; both RAM clocks are tied to clk.

Parameters:
- NREQ, 2, number of requesting clients (2..8).
- ADDR_W, 10, RAM address width; depth 1024.
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  single clock for arbiter and both RAM ports.
- rst_n  in  1  synchronous active-low reset.
- wr_req  in  NREQ  per-client write request; held until granted.
- wr_addr  in  NREQ*ADDR_W  packed write addresses; client i occupies slice i.
- wr_data  in  NREQ*DATA_W  packed write data.
- wr_gnt  out  NREQ  one-hot write grant, combinational.
- rd_req  in  NREQ  per-client read request; held until granted.
- rd_addr  in  NREQ*ADDR_W  packed read addresses.
- rd_gnt  out  NREQ  one-hot read grant, combinational.
- rd_rsp_valid  out  NREQ  one-hot, registered; marks the cycle rd_rsp_data is valid for that client.
- rd_rsp_data  out  DATA_W  read data.
- ram_ena, ram_wea  out  1  port A enables.
- ram_addra  out  ADDR_W  port A address.
- ram_dina  out  DATA_W  port A data.
- ram_enb  out  1  port B enable.
- ram_addrb  out  ADDR_W  port B address.
- ram_doutb  in  DATA_W  registered RAM read data (1-cycle latency).

Behaviour:
- Reset (rst_n=0 at posedge):
  - Both round-robin pointers go to 0 (client 0 highest priority).
  - rd_rsp_valid goes to 0 and the bypass registers clear.
  - While rst_n=0, wr_gnt, rd_gnt, ram_ena, ram_wea and ram_enb are all 0; requests are ignored.
- Arbitration, per port, every cycle:
  - Search starts at the pointer index and wraps modulo NREQ.
  - The first asserted request wins; the grant is one-hot or zero.
  - A handshake completes when req & gnt are high at the posedge.
  - After a grant to client k, the pointer becomes (k+1) mod NREQ; with no grant it holds.
- Write path: on a write grant to k, ram_ena=ram_wea=1, ram_addra=wr_addr[k], ram_dina=wr_data[k], all in the same cycle. With no grant, ram_ena=ram_wea=0 and the address/data outputs are don't-care (driven 0).
- Read path: on a read grant to k, ram_enb=1 and ram_addrb=rd_addr[k]. The next cycle, rd_rsp_valid[k]=1 and rd_rsp_data=ram_doutb. Read latency is grant+1; one response per cycle maximum.
- Read throughput: back-to-back read grants are allowed, at one per cycle.
- Hazard (write granted, read winner, equal addresses, same cycle): handled per Optional Feature.
- A client may request write and read in the same cycle; the two ports are independent.
- A request dropped before grant is legal and is simply not served.
- Reset mid-operation: a pending response is discarded (rd_rsp_valid=0 the cycle after reset); no RAM access is issued during reset.

Optional Feature:
- Macro: RAM_ARB_RAW_BYPASS_EN.
- Defined:
  - The conflicting read is granted normally.
  - wr data is captured into a registered bypass; the next-cycle rd_rsp_data equals the written data instead of ram_doutb.
  - Result is write-first semantics regardless of the RAM collision mode.
- Undefined:
  - On conflict, the read winner's grant is suppressed (rd_gnt=0, ram_enb=0) and the read pointer holds.
  - The read is retried next cycle and returns the newly written data.
  - Cost: one cycle of read stall per conflict.

Decomposition:
- Package ram_arb_pkg holds:
  - ADDR_W and DATA_W defaults, matching the shared defines;
  - typedefs addr_t, data_t;
  - req_vec_t (logic [NREQ-1:0]);
  - function rr_pick (mask rotated by pointer, returns one-hot).
- Sub-module rr_arbiter (req, advance enable -> gnt, internal pointer) is instantiated twice, once per port.

Test Plan:
- Reset: hold rst_n=0 with all requests high -> all grants, enables and rd_rsp_valid are 0. Release -> client 0 granted on both ports first.
- Round robin: wr_req=2'b11 held for 4 cycles -> wr_gnt sequence 01,10,01,10, and ram_addra tracks the granted client's address.
- Read latency: client 1 reads addr 0x005, preloaded 0x5A -> rd_gnt=10 at cycle t; rd_rsp_valid=10 and rd_rsp_data=0x5A at t+1.
- Hazard without macro: write 0x33 to 0x010 (client 0) while client 1 reads 0x010 in the same cycle -> rd_gnt=0 at t; granted at t+1; response at t+2 is 0x33.
- Hazard with RAM_ARB_RAW_BYPASS_EN: same stimulus -> rd_gnt=10 at t; response at t+1 is 0x33.
- Reset mid-read: read granted at t, rst_n=0 at t+1 -> rd_rsp_valid=0 at t+1 and t+2; pointers read 0 after reset.
